// File: rtl/soma_pkg.sv
// Shared types for the Soma adder datapath and its operand feeder.
// Holds the operand width, the loader FSM states and the operand type.
package soma_pkg;

  localparam int W_DEFAULT = 64;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    DONE   = 2'd2
  } loader_state_t;

  typedef logic [W_DEFAULT-1:0] operand_t;

endpackage

// File: rtl/operand_loader.sv
// Byte-serial operand loader for Soma: assembles A then B, LSB first,
// and presents each pair atomically with op_valid/sum_valid pulses.
module operand_loader
  import soma_pkg::*;
#(
  parameter int BYTES = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic [8*BYTES-1:0] N_1,
  output logic [8*BYTES-1:0] N_2,
  output logic               op_valid,
  output logic               sum_valid
);

  localparam int W  = 8 * BYTES;
  localparam int CW = (BYTES > 1) ? $clog2(BYTES) : 1;

  loader_state_t state, state_n;

  logic [CW-1:0] cnt, cnt_n;
  logic [W-1:0]  sh_a, sh_a_n;
  logic [W-1:0]  sh_b, sh_b_n;
  logic [W-1:0]  n1_n, n2_n;
  logic          opv_n;
  logic          acc;
  logic          last;

  assign in_ready = (state != DONE);
  assign acc      = in_valid && in_ready;
  assign last     = (cnt == CW'(BYTES - 1));

  // On the final B byte, N_2 gets the shadow with that byte merged in.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sh_a_n  = sh_a;
    sh_b_n  = sh_b;
    n1_n    = N_1;
    n2_n    = N_2;
    opv_n   = 1'b0;
    unique case (state)
      LOAD_A: begin
        if (acc) begin
          sh_a_n[{cnt, 3'b000} +: 8] = in_data;
          if (last) begin
            cnt_n   = '0;
            state_n = LOAD_B;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      LOAD_B: begin
        if (acc) begin
          sh_b_n[{cnt, 3'b000} +: 8] = in_data;
          if (last) begin
            cnt_n   = '0;
            n1_n    = sh_a;
            n2_n    = sh_b_n;
            opv_n   = 1'b1;
            state_n = DONE;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      DONE: begin
        state_n = LOAD_A;
      end
      default: begin
        state_n = LOAD_A;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= LOAD_A;
      cnt       <= '0;
      sh_a      <= '0;
      sh_b      <= '0;
      N_1       <= '0;
      N_2       <= '0;
      op_valid  <= 1'b0;
      sum_valid <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      sh_a      <= sh_a_n;
      sh_b      <= sh_b_n;
      N_1       <= n1_n;
      N_2       <= n2_n;
      op_valid  <= opv_n;
      sum_valid <= op_valid;
    end
  end

endmodule

// File: tb/tb_operand_loader.sv
// Scoreboard bench for operand_loader: random and directed pairs,
// bubbles, back-to-back streaming and reset mid-load.
module tb_operand_loader;

  localparam int BYTES = 8;
  localparam int W     = 8 * BYTES;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } pair_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [7:0]   in_data = 8'h00;
  logic         in_ready;
  logic [W-1:0] N_1;
  logic [W-1:0] N_2;
  logic         op_valid;
  logic         sum_valid;

  operand_loader #(.BYTES(BYTES)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .N_1      (N_1),
    .N_2      (N_2),
    .op_valid (op_valid),
    .sum_valid(sum_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  pair_t exp_q[$];
  pair_t held = '0;
  int    done_cyc  = -10;
  int    done_edge = -10;

  task automatic chk(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // Monitor: timing from the reference cycle model, data from the queue.
  always @(negedge clk) begin
    chk("in_ready", W'(in_ready), W'(cyc != done_cyc));
    chk("op_valid", W'(op_valid), W'(cyc == done_cyc));
    chk("sum_valid", W'(sum_valid), W'(cyc == done_cyc + 1));
    if (op_valid) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_op cyc=%0d got=1 want=0", cyc);
      end else begin
        held = exp_q.pop_front();
      end
    end
    chk("N_1", N_1, held.a);
    chk("N_2", N_2, held.b);
  end

  task automatic drive_byte(input logic [7:0] b, input int nbub);
    repeat (nbub) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk); #1;
    if (cyc == done_edge) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("rst_N_1", N_1, '0);
    chk("rst_N_2", N_2, '0);
    chk("rst_op", W'(op_valid), '0);
    chk("rst_sum", W'(sum_valid), '0);
    chk("rst_ready", W'(in_ready), W'(1));
    held = '0;
    @(negedge clk); #1;
    rst = 1'b0;
  endtask

  // Bubbles land at random non-first byte slots; abort_b >= 0 resets
  // after that many B bytes have been accepted.
  task automatic send_pair(input logic [W-1:0] a, input logic [W-1:0] b,
                           input int bub_a, input int bub_b,
                           input int abort_b);
    int ba[BYTES];
    int bb[BYTES];
    pair_t p;
    foreach (ba[i]) begin ba[i] = 0; bb[i] = 0; end
    repeat (bub_a) ba[$urandom_range(BYTES - 1, 1)]++;
    repeat (bub_b) bb[$urandom_range(BYTES - 1, 1)]++;
    p.a = a;
    p.b = b;
    exp_q.push_back(p);
    for (int i = 0; i < BYTES; i++) drive_byte(a[8*i +: 8], ba[i]);
    for (int i = 0; i < BYTES; i++) begin
      if (i == abort_b) begin
        void'(exp_q.pop_back());
        do_reset();
        return;
      end
      drive_byte(b[8*i +: 8], bb[i]);
    end
    done_cyc  = cyc;
    done_edge = cyc + 1;
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    send_pair(64'd4, 64'd6, 0, 0, -1);
    send_pair(64'h0123456789ABCDEF, 64'd1, 0, 0, -1);
    send_pair(64'd13, 64'd50, 3, 2, -1);
    send_pair(64'd4, 64'd7, 0, 0, -1);
    send_pair(64'd49, 64'd74, 0, 0, -1);
    send_pair({W{1'b1}}, 64'd1, 0, 0, -1);
    send_pair(64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 0, 0, 5);
    send_pair(64'd2, 64'd3, 0, 0, -1);
    for (int n = 0; n < 24; n++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (n % 7 == 3) ra = {W{1'b1}};
      send_pair(ra, rb, $urandom_range(3, 0), $urandom_range(3, 0),
                (n % 9 == 4) ? int'($urandom_range(BYTES - 1, 0)) : -1);
    end
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("queue_drained", W'(exp_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
